id_regread_pipe: RTL and testbench
==================================

// Module: id_regread_pipe
// PURPOSE
// - Parametrised decode-stage register read block for the lc3b pipeline: register file with
//   writeback port, link-register destination select and PC/data writeback select.
// - Adds a pending-write scoreboard (RAW/WAW stall), optional WB->ID bypass and a registered
//   ID/EX output stage with valid/ready handshake and flush.
// - Sits between IF/decode control and EX; consumes the writeback bus from WB.
// PARAMETERS
// - WIDTH     16  data word width
// - NREGS     8   architectural registers
// - ADDR_W    3   register index width, = $clog2(NREGS)
// - LINK_REG  7   destination index forced when link select is set
// PORTS
// - clk           in   1       clock, all state on rising edge
// - reset_n       in   1       asynchronous active-low reset
// - in_valid      in   1       decoded instruction presented
// - in_ready      out  1       instruction accepted this cycle when in_valid && in_ready
// - in_sr1        in   ADDR_W  source 1 index
// - in_sr2        in   ADDR_W  source 2 index (store-source mux resolved upstream)
// - in_dr         in   ADDR_W  destination index
// - in_dr_we      in   1       instruction writes a register
// - in_link       in   1       destination is LINK_REG (overrides in_dr)
// - in_imm        in   WIDTH   sign/zero-extended immediate, passed through
// - flush         in   1       kill the instruction held in the output register
// - wb_valid      in   1       writeback this cycle
// - wb_dr         in   ADDR_W  writeback index (already link-resolved)
// - wb_sel_pc     in   1       1: write wb_pc, 0: write wb_data
// - wb_data       in   WIDTH   writeback result
// - wb_pc         in   WIDTH   writeback return PC
// - out_valid     out  1       ID/EX register holds a live instruction
// - out_ready     in   1       EX consumes when out_valid && out_ready
// - out_sr1_data  out  WIDTH   source 1 operand
// - out_sr2_data  out  WIDTH   source 2 operand
// - out_imm       out  WIDTH   registered in_imm
// - out_dr        out  ADDR_W  resolved destination index
// - out_dr_we     out  1       registered in_dr_we
// BEHAVIOUR
// - Reset (async, reset_n=0): all NREGS registers, pend[] and every output register -> 0; out_valid=0.
// - Writeback: on wb_valid, reg[wb_dr] <= wb_sel_pc ? wb_pc : wb_data at the clock edge.
// - dest = in_link ? LINK_REG : in_dr.
// - Scoreboard pend[NREGS]:
//   - Accept with in_dr_we sets pend[dest].
//   - wb_valid clears pend[wb_dr].
//   - Same-cycle set and clear on one index: set wins.
// - Hazard when in_valid and any of:
//   - src (sr1 or sr2) pending and not bypass-hit;
//   - in_dr_we && pend[dest] (WAW; one outstanding writer per register).
// - in_ready = (!out_valid || out_ready) && !hazard && !flush.
// - Accept: next cycle out_valid=1, operands/imm/dest/we captured. Latency 1 cycle.
// - Hold: out_valid && !out_ready -> all outputs stable.
// - Drain: consume without accept -> out_valid=0.
// - Flush: next cycle out_valid=0. If the killed instruction had out_dr_we, clear pend[out_dr];
//   that clear loses to a same-cycle set.
// - Operand read: same-cycle wb to the read index (wb_valid && wb_dr==src) with bypass -> wb value.
//   Otherwise the array value.
// - Reset mid-operation: all state lost, pend cleared, no partial writes.
// CONFIGURATION
// - ID_BYPASS_EN defined:
//   - wb value forwarded combinationally to operand capture;
//   - bypass-hit satisfies the pending source, so the instruction is accepted in the writeback cycle.
// - ID_BYPASS_EN undefined:
//   - no forwarding; bypass-hit is always 0;
//   - a pending source stalls until the cycle after writeback, when it reads the updated array.
// TESTING
// - Reset: hold reset_n=0 with in_valid=1 -> in_ready=1 after release, out_valid=0, reg reads 0.
// - Basic: wb R3=16'h1234, then issue sr1=3,sr2=3 -> next cycle out_valid=1, both operands 16'h1234.
// - RAW: issue dr=2 (we), then sr1=2; wb R2=16'hBEEF 3 cycles later.
//   - bypass: accepted in wb cycle, operand 16'hBEEF;
//   - no bypass: accepted one cycle later, same operand.
// - Link/WAW: issue in_link=1 (dest R7), then dr=7 -> second stalls until wb_dr=7; out_dr=7 on first.
// - Backpressure/flush: out_ready=0 for 4 cycles -> outputs stable, in_ready=0.
//   - Then flush with out_dr_we=1, dr=5 -> out_valid=0, pend[5]=0, dr=5 writer accepted.
// - wb_sel_pc=1, wb_pc=16'h3002, wb_data=16'hFFFF, wb_dr=7 -> R7 reads 16'h3002.

Source files
------------

// File: rtl/id_regread_pipe.sv
// id_regread_pipe: decode-stage register read with pending-write scoreboard and registered ID/EX stage.
// Define ID_BYPASS_EN to forward the same-cycle writeback value into operand capture.
module id_regread_pipe #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 8,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int LINK_REG = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_sr1,
  input  logic [ADDR_W-1:0] in_sr2,
  input  logic [ADDR_W-1:0] in_dr,
  input  logic              in_dr_we,
  input  logic              in_link,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dr,
  input  logic              wb_sel_pc,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic [WIDTH-1:0]  wb_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sr1_data,
  output logic [WIDTH-1:0]  out_sr2_data,
  output logic [WIDTH-1:0]  out_imm,
  output logic [ADDR_W-1:0] out_dr,
  output logic              out_dr_we
);
  logic [WIDTH-1:0]  r_regs [NREGS];
  logic [NREGS-1:0]  r_pend;
  logic [NREGS-1:0]  w_pend_nxt;
  logic [ADDR_W-1:0] w_dest;
  logic [WIDTH-1:0]  w_wb_val;
  logic [WIDTH-1:0]  w_op1;
  logic [WIDTH-1:0]  w_op2;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_hazard;
  logic              w_acc;
  assign w_dest   = in_link ? ADDR_W'(LINK_REG) : in_dr;
  assign w_wb_val = wb_sel_pc ? wb_pc : wb_data;
`ifdef ID_BYPASS_EN
  assign w_hit1 = wb_valid && (wb_dr == in_sr1);
  assign w_hit2 = wb_valid && (wb_dr == in_sr2);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif
  assign w_op1    = w_hit1 ? w_wb_val : r_regs[in_sr1];
  assign w_op2    = w_hit2 ? w_wb_val : r_regs[in_sr2];
  // WAW gets no bypass relief: the old writer must retire before a new one issues
  assign w_hazard = in_valid && ((r_pend[in_sr1] && !w_hit1) || (r_pend[in_sr2] && !w_hit2) ||
                                 (in_dr_we && r_pend[w_dest]));
  assign in_ready = (!out_valid || out_ready) && !w_hazard && !flush;
  assign w_acc    = in_valid && in_ready;
  // clears first so a same-cycle set on the same index wins
  always_comb begin
    w_pend_nxt = r_pend;
    if (flush && out_valid && out_dr_we) w_pend_nxt[out_dr] = 1'b0;
    if (wb_valid) w_pend_nxt[wb_dr] = 1'b0;
    if (w_acc && in_dr_we) w_pend_nxt[w_dest] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      if (wb_valid) r_regs[wb_dr] <= w_wb_val;
      r_pend <= w_pend_nxt;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_sr1_data <= '0;
      out_sr2_data <= '0;
      out_imm      <= '0;
      out_dr       <= '0;
      out_dr_we    <= 1'b0;
    end else if (w_acc) begin
      out_valid    <= 1'b1;
      out_sr1_data <= w_op1;
      out_sr2_data <= w_op2;
      out_imm      <= in_imm;
      out_dr       <= w_dest;
      out_dr_we    <= in_dr_we;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_regread_pipe.sv
// tb_id_regread_pipe: directed checks of id_regread_pipe (reset, read, RAW, link/WAW, backpressure, flush, wb select).
module tb_id_regread_pipe;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_dr_we, in_link, flush;
  logic [2:0]  in_sr1, in_sr2, in_dr, wb_dr, out_dr;
  logic [15:0] in_imm, wb_data, wb_pc, out_sr1_data, out_sr2_data, out_imm;
  logic        wb_valid, wb_sel_pc, out_valid, out_ready, out_dr_we;
  int          n_assert = 0;
  int          n_fail = 0;

  id_regread_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .in_dr_we(in_dr_we),
    .in_link(in_link), .in_imm(in_imm), .flush(flush), .wb_valid(wb_valid),
    .wb_dr(wb_dr), .wb_sel_pc(wb_sel_pc), .wb_data(wb_data), .wb_pc(wb_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_sr1_data(out_sr1_data),
    .out_sr2_data(out_sr2_data), .out_imm(out_imm), .out_dr(out_dr), .out_dr_we(out_dr_we)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b1; in_sr1 = 0; in_sr2 = 0; in_dr = 0; in_dr_we = 0;
    in_link = 0; in_imm = 0; flush = 0; wb_valid = 0; wb_dr = 0; wb_sel_pc = 0;
    wb_data = 0; wb_pc = 0; out_ready = 1;
    tick(); tick();
    chk("reset_out_valid", out_valid, 0);
    reset_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid_after", out_valid, 0);
    tick();
    chk("reset_accept_valid", out_valid, 1);
    chk("reset_reg_read", out_sr1_data, 16'h0000);
    in_valid = 0;
    // basic read after writeback
    wb_valid = 1; wb_dr = 3; wb_data = 16'h1234;
    tick();
    wb_valid = 0; in_valid = 1; in_sr1 = 3; in_sr2 = 3;
    #1;
    chk("basic_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("basic_valid", out_valid, 1);
    chk("basic_sr1", out_sr1_data, 16'h1234);
    chk("basic_sr2", out_sr2_data, 16'h1234);
    tick();
    chk("basic_drain", out_valid, 0);
    // RAW on R2
    in_valid = 1; in_sr1 = 0; in_sr2 = 0; in_dr = 2; in_dr_we = 1;
    #1;
    chk("raw_writer_ready", in_ready, 1);
    tick();
    in_sr1 = 2; in_dr = 0; in_dr_we = 0;
    #1;
    chk("raw_stall0", in_ready, 0);
    tick();
    chk("raw_stall1", in_ready, 0);
    tick();
    chk("raw_stall2", in_ready, 0);
    wb_valid = 1; wb_dr = 2; wb_data = 16'hBEEF;
    #1;
`ifdef ID_BYPASS_EN
    chk("raw_wb_cycle_ready", in_ready, 1);
    tick();
    wb_valid = 0; in_valid = 0;
`else
    chk("raw_wb_cycle_ready", in_ready, 0);
    tick();
    wb_valid = 0;
    #1;
    chk("raw_after_wb_ready", in_ready, 1);
    tick();
    in_valid = 0;
`endif
    chk("raw_valid", out_valid, 1);
    chk("raw_operand", out_sr1_data, 16'hBEEF);
    tick();
    // link destination and WAW on R7
    in_valid = 1; in_sr1 = 0; in_link = 1; in_dr = 0; in_dr_we = 1;
    #1;
    chk("link_ready", in_ready, 1);
    tick();
    chk("link_out_dr", out_dr, 7);
    chk("link_out_we", out_dr_we, 1);
    in_link = 0; in_dr = 7;
    #1;
    chk("waw_stall0", in_ready, 0);
    tick();
    chk("waw_stall1", in_ready, 0);
    wb_valid = 1; wb_dr = 7; wb_data = 16'h0007;
    #1;
    chk("waw_wb_cycle", in_ready, 0);
    tick();
    wb_valid = 0;
    #1;
    chk("waw_after_wb", in_ready, 1);
    tick();
    in_valid = 0; in_dr_we = 0; in_dr = 0;
    chk("waw_valid", out_valid, 1);
    chk("waw_out_dr", out_dr, 7);
    // PC writeback select clears pend[7] and writes R7
    wb_valid = 1; wb_dr = 7; wb_sel_pc = 1; wb_pc = 16'h3002; wb_data = 16'hFFFF;
    tick();
    wb_valid = 0; wb_sel_pc = 0; in_valid = 1; in_sr1 = 7; in_sr2 = 0;
    #1;
    chk("pcsel_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("pcsel_r7", out_sr1_data, 16'h3002);
    tick();
    chk("pcsel_drain", out_valid, 0);
    // backpressure then flush of a dr=5 writer
    in_valid = 1; in_sr1 = 3; in_sr2 = 7; in_dr = 5; in_dr_we = 1; in_imm = 16'hA5A5; out_ready = 0;
    #1;
    chk("bp_first_ready", in_ready, 1);
    tick();
    in_sr1 = 0; in_sr2 = 0; in_imm = 16'h0055;
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_imm", out_imm, 16'hA5A5);
      chk("bp_sr1", out_sr1_data, 16'h1234);
      chk("bp_sr2", out_sr2_data, 16'h3002);
      chk("bp_dr", out_dr, 5);
      tick();
    end
    flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 0;
    chk("flush_valid", out_valid, 0);
    #1;
    chk("flush_pend_cleared", in_ready, 1);
    tick();
    chk("flush_writer_valid", out_valid, 1);
    chk("flush_writer_dr", out_dr, 5);
    chk("flush_writer_imm", out_imm, 16'h0055);
    // async reset mid-operation
    in_valid = 0; out_ready = 1;
    #2 reset_n = 0;
    #1;
    chk("midreset_valid", out_valid, 0);
    #1 reset_n = 1;
    tick();
    in_valid = 1; in_sr1 = 3; in_sr2 = 3; in_dr = 5; in_dr_we = 1;
    #1;
    chk("midreset_pend_clear", in_ready, 1);
    tick();
    in_valid = 0;
    chk("midreset_reg_cleared", out_sr1_data, 16'h0000);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
